// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider producing quotient (Lo)
// and remainder (Hi) for signed DIV and unsigned DIVU, one quotient bit per cycle.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic             busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] raw_a;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             unused_trial_bit;

    // Operand magnitudes and one restoring trial-subtract step on the current partial remainder
    always_comb begin
        abs_a   = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        abs_b   = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;
        shifted = {rem, quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        borrow  = trial[WIDTH+1];
        unused_trial_bit = trial[WIDTH];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and handshake outputs
    always_comb begin
        state_next = state;
        validOut   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (validIn) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                validOut   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands, iterate, then apply sign fix-up into Hi/Lo
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            raw_a    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            count    <= '0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (validIn) begin
                        divisor  <= abs_b;
                        quo      <= abs_a;
                        rem      <= '0;
                        raw_a    <= SrcA;
                        neg_q    <= (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) & sign;
                        neg_r    <= SrcA[WIDTH-1] & sign;
                        div_zero <= (SrcB == '0);
                        count    <= CW'(WIDTH - 1);
                    end
                end
                BUSY: begin
                    quo   <= {quo[WIDTH-2:0], ~borrow};
                    rem   <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    count <= count - 1'b1;
                end
                FIX: begin
                    if (div_zero) begin
                        Lo <= '1;
                        Hi <= raw_a;
                    end else begin
                        Lo <= neg_q ? -quo : quo;
                        Hi <= neg_r ? -rem : rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed table, multi-cycle corner sequences and random
// operands for iter_divider, checked against hand values and a reference model.
module tb_iter_divider;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 33;

    logic             clk = 1'b0;
    logic             reset;
    logic             validIn;
    logic             sign;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             validOut;
    logic             busy;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[14];

    iter_divider #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .validIn  (validIn),
        .sign     (sign),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .validOut (validOut),
        .busy     (busy),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Start one operation with validIn held until validOut, then observe the cycle after
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] lo, output logic [31:0] hi, output int lat,
                                 output logic busy_start, output logic busy_after, output logic vo_after);
        SrcA    = a;
        SrcB    = b;
        sign    = s;
        validIn = 1'b1;
        @(posedge clk); #1;
        busy_start = busy;
        lat = 0;
        lo  = '0;
        hi  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (validOut) begin
                lat = i;
                lo  = Lo;
                hi  = Hi;
                break;
            end
        end
        validIn = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
        vo_after   = validOut;
    endtask

    task automatic runVector(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                             input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        logic [31:0] lo, hi;
        int          lat;
        logic        bs, ba, va;
        applyStimulus(a, b, s, lo, hi, lat, bs, ba, va);
        checkOutput({name, " busy@capture"}, 32'(bs), 32'd1);
        checkOutput({name, " latency"}, 32'(lat), 32'(LATENCY));
        checkOutput({name, " Lo"}, lo, exp_lo);
        checkOutput({name, " Hi"}, hi, exp_hi);
        checkOutput({name, " busy after"}, 32'(ba), 32'd0);
        checkOutput({name, " validOut after"}, 32'(va), 32'd0);
    endtask

    function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                                     output logic [31:0] q, output logic [31:0] r);
        if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin
        int          pulses;
        int          pulse_at;
        int          lat;
        logic [31:0] ra, rb, rq, rr;
        logic        rs;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
        vecs[3]  = '{32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678};
        vecs[4]  = '{32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678};
        vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
        vecs[6]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0};
        vecs[7]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF};
        vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'd1,          32'd0};
        vecs[9]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000};
        vecs[10] = '{32'hF0000000,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hF0000000};
        vecs[11] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5};
        vecs[12] = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE};
        vecs[13] = '{32'hFFFFFFFF,   32'd10,         1'b0, 32'h19999999,   32'd5};

        reset   = 1'b1;
        validIn = 1'b0;
        sign    = 1'b0;
        SrcA    = '0;
        SrcB    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset validOut", 32'(validOut), 32'd0);
        checkOutput("reset Hi", Hi, 32'd0);
        checkOutput("reset Lo", Lo, 32'd0);
        validIn = 1'b1;
        SrcA    = 32'd50;
        SrcB    = 32'd5;
        @(posedge clk); #1;
        checkOutput("validIn under reset busy", 32'(busy), 32'd0);
        validIn = 1'b0;
        reset   = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lo, vecs[i].hi);
        end

        SrcA    = 32'd1000;
        SrcB    = 32'd13;
        sign    = 1'b0;
        validIn = 1'b1;
        @(posedge clk); #1;
        checkOutput("stab busy@capture", 32'(busy), 32'd1);
        pulses   = 0;
        pulse_at = 0;
        for (int k = 1; k <= LATENCY; k++) begin
            SrcA = $urandom;
            SrcB = $urandom;
            sign = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (validOut) begin
                pulses++;
                pulse_at = k;
            end
        end
        checkOutput("stab pulse count", 32'(pulses), 32'd1);
        checkOutput("stab pulse edge", 32'(pulse_at), 32'(LATENCY));
        checkOutput("stab Lo", Lo, 32'd76);
        checkOutput("stab Hi", Hi, 32'd12);
        SrcA = 32'hFFFFFFAF;
        SrcB = 32'd9;
        sign = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b gap busy", 32'(busy), 32'd0);
        checkOutput("b2b gap validOut", 32'(validOut), 32'd0);
        @(posedge clk); #1;
        checkOutput("b2b busy@capture", 32'(busy), 32'd1);
        checkOutput("b2b Lo held", Lo, 32'd76);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (validOut) begin
                lat = i;
                break;
            end
        end
        validIn = 1'b0;
        checkOutput("b2b latency", 32'(lat), 32'(LATENCY));
        checkOutput("b2b Lo", Lo, 32'hFFFFFFF7);
        checkOutput("b2b Hi", Hi, 32'd0);
        @(posedge clk); #1;
        checkOutput("b2b busy after", 32'(busy), 32'd0);

        SrcA    = 32'd1000;
        SrcB    = 32'd3;
        sign    = 1'b0;
        validIn = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        reset   = 1'b1;
        validIn = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset validOut", 32'(validOut), 32'd0);
        checkOutput("midreset Hi", Hi, 32'd0);
        checkOutput("midreset Lo", Lo, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        runVector("post-reset 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                rb = rb >> $urandom_range(0, 31);
            end
            if (rb == 32'd0) begin
                rb = 32'd1;
            end
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) begin
                rb = 32'd3;
            end
            refModel(ra, rb, rs, rq, rr);
            runVector($sformatf("rand%0d", n), ra, rb, rs, rq, rr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
